// File: rtl/src_pkg.sv
// Shared definitions for the SRC fetch/decode front end:
// state codes, instruction field positions and widths.
package src_pkg;

    localparam int OPC_HI    = 31;
    localparam int OPC_LO    = 27;
    localparam int RA_LO     = 22;
    localparam int RB_LO     = 17;
    localparam int RC_LO     = 12;
    localparam int C2_W      = 17;
    localparam int C1_W      = 22;
    localparam int OPC_W     = 5;
    localparam int REG_IDX_W = 5;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_FETCH = 2'd1;
    localparam logic [1:0] S_VALID = 2'd2;
    localparam logic [1:0] S_ERR   = 2'd3;

    typedef struct packed {
        logic [OPC_W-1:0]     opcode;
        logic [REG_IDX_W-1:0] ra;
        logic [REG_IDX_W-1:0] rb;
        logic [REG_IDX_W-1:0] rc;
        logic [C1_W-1:0]      c1;
        logic [31:0]          c2_sext;
    } src_fields_t;

    function automatic src_fields_t src_decode(input logic [31:0] w);
        src_fields_t f;
        f.opcode  = w[OPC_HI:OPC_LO];
        f.ra      = w[RA_LO+REG_IDX_W-1:RA_LO];
        f.rb      = w[RB_LO+REG_IDX_W-1:RB_LO];
        f.rc      = w[RC_LO+REG_IDX_W-1:RC_LO];
        f.c1      = w[C1_W-1:0];
        f.c2_sext = {{(32-C2_W){w[C2_W-1]}}, w[C2_W-1:0]};
        return f;
    endfunction

endpackage

// File: rtl/src_fetch_unit_if.sv
// Fetch bus between the SRC fetch unit (master) and the
// memory controller (slave): req/ack with address and read data.
interface src_fetch_unit_if #(
    parameter int ADDR_W = 16
);
    logic              mem_req;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_rdata;
    logic              mem_ack;

    modport master (
        output mem_req,
        output mem_addr,
        input  mem_rdata,
        input  mem_ack
    );

    modport slave (
        input  mem_req,
        input  mem_addr,
        output mem_rdata,
        output mem_ack
    );
endinterface

// File: rtl/src_fetch_timer.sv
// Bus-timeout counter: counts cycles while run is high, restarts on clr;
// expired flags the cycle in which the TIMEOUT_CYC-th wait cycle elapses.
module src_fetch_timer #(
    parameter int TIMEOUT_CYC = 255
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic run,
    output logic expired
);

    localparam int CW = (TIMEOUT_CYC < 2) ? 1 : $clog2(TIMEOUT_CYC + 1);
    localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYC - 1);

    logic [CW-1:0] cnt;

    assign expired = run && !clr && (cnt == LAST);

    // Count wait cycles, saturating at the expiry value.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (run && (cnt != LAST)) begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/src_fetch_unit.sv
// SRC instruction fetch/decode front end: owns PC and IR, fetches over
// mem, presents decoded fields. Optional watchdog: SRC_FETCH_TIMEOUT_EN.
module src_fetch_unit
    import src_pkg::*;
#(
    parameter int ADDR_W      = 16,
    parameter int RESET_PC    = 0,
    parameter int PC_STEP     = 1,
    parameter int TIMEOUT_CYC = 255
) (
    input  logic                 clk,
    input  logic                 rst_n,
    src_fetch_unit_if.master     mem,
    input  logic                 stall,
    input  logic                 redirect_valid,
    input  logic [ADDR_W-1:0]    redirect_pc,
    output logic                 ir_valid,
    input  logic                 ir_ack,
    output logic [31:0]          ir,
    output logic [ADDR_W-1:0]    pc,
    output logic [OPC_W-1:0]     opcode,
    output logic [REG_IDX_W-1:0] ra,
    output logic [REG_IDX_W-1:0] rb,
    output logic [REG_IDX_W-1:0] rc,
    output logic [C1_W-1:0]      c1,
    output logic [31:0]          c2_sext,
    output logic                 fault
);

    localparam logic [ADDR_W-1:0] PC_RST = ADDR_W'(RESET_PC);
    localparam logic [ADDR_W-1:0] STEP   = ADDR_W'(PC_STEP);

    logic [1:0]        state;
    logic [1:0]        state_nx;
    logic [ADDR_W-1:0] pc_q;
    logic [ADDR_W-1:0] pc_nx;
    logic [31:0]       ir_q;
    logic [31:0]       ir_nx;
    logic              expired;
    src_fields_t       fld;

    assign mem.mem_req  = (state == S_FETCH);
    assign mem.mem_addr = pc_q;
    assign ir_valid     = (state == S_VALID);
    assign ir           = ir_q;
    assign pc           = pc_q;

    assign fld     = src_decode(ir_q);
    assign opcode  = fld.opcode;
    assign ra      = fld.ra;
    assign rb      = fld.rb;
    assign rc      = fld.rc;
    assign c1      = fld.c1;
    assign c2_sext = fld.c2_sext;

`ifdef SRC_FETCH_TIMEOUT_EN
    logic fault_q;
    logic fault_nx;

    assign fault = fault_q;

    src_fetch_timer #(
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) u_timer (
        .clk     (clk),
        .rst_n   (rst_n),
        .clr     ((state != S_FETCH) || mem.mem_ack || redirect_valid),
        .run     (state == S_FETCH),
        .expired (expired)
    );
`else
    logic [31:0] unused_tmo;

    assign unused_tmo = 32'(TIMEOUT_CYC);
    assign expired    = 1'b0;
    assign fault      = 1'b0;
`endif

    // Next-state, PC and IR selection; redirect outranks every other event.
    always_comb begin
        state_nx = state;
        pc_nx    = pc_q;
        ir_nx    = ir_q;
`ifdef SRC_FETCH_TIMEOUT_EN
        fault_nx = fault_q;
`endif
        unique case (state)
            S_IDLE: begin
                if (redirect_valid) pc_nx = redirect_pc;
                if (!stall) state_nx = S_FETCH;
            end
            S_FETCH: begin
                if (redirect_valid) begin
                    pc_nx = redirect_pc;
                end else if (mem.mem_ack) begin
                    ir_nx    = mem.mem_rdata;
                    pc_nx    = pc_q + STEP;
                    state_nx = S_VALID;
                end else if (expired) begin
`ifdef SRC_FETCH_TIMEOUT_EN
                    fault_nx = 1'b1;
                    state_nx = S_ERR;
`endif
                end
            end
            S_VALID: begin
                if (redirect_valid || ir_ack) begin
                    if (redirect_valid) pc_nx = redirect_pc;
                    state_nx = stall ? S_IDLE : S_FETCH;
                end
            end
`ifdef SRC_FETCH_TIMEOUT_EN
            S_ERR: begin
                if (redirect_valid) begin
                    pc_nx    = redirect_pc;
                    fault_nx = 1'b0;
                    state_nx = S_FETCH;
                end
            end
`endif
            default: state_nx = S_IDLE;
        endcase
    end

    // Architectural state registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
            pc_q  <= PC_RST;
            ir_q  <= '0;
        end else begin
            state <= state_nx;
            pc_q  <= pc_nx;
            ir_q  <= ir_nx;
        end
    end

`ifdef SRC_FETCH_TIMEOUT_EN
    // Sticky bus-timeout flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) fault_q <= 1'b0;
        else        fault_q <= fault_nx;
    end
`endif

endmodule

// File: tb/tb_src_fetch_unit.sv
// Self-checking bench for src_fetch_unit: directed scenarios plus a
// randomized run against a transaction-level model.
module tb_src_fetch_unit;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        stall = 1'b1;
    logic        redirect_valid = 1'b0;
    logic [15:0] redirect_pc = '0;
    logic        ir_ack = 1'b0;
    logic        ir_valid;
    logic [31:0] ir;
    logic [15:0] pc;
    logic [4:0]  opcode, ra, rb, rc;
    logic [21:0] c1;
    logic [31:0] c2_sext;
    logic        fault;

    logic        rst2_n = 1'b0;
    logic        ir_valid2;
    logic [31:0] ir2;
    logic [3:0]  pc2;
    logic [4:0]  opcode2, ra2, rb2, rc2;
    logic [21:0] c12;
    logic [31:0] c2_sext2;
    logic        fault2;
    logic        redirect2_valid = 1'b0;
    logic [3:0]  redirect2_pc = '0;

    int n_tests = 0;
    int n_fail  = 0;
    logic [31:0] last_word;

    src_fetch_unit_if #(.ADDR_W(16)) bus ();
    src_fetch_unit_if #(.ADDR_W(4))  bus2 ();

    src_fetch_unit #(
        .ADDR_W(16), .RESET_PC(0), .PC_STEP(1), .TIMEOUT_CYC(8)
    ) dut (
        .clk(clk), .rst_n(rst_n), .mem(bus),
        .stall(stall), .redirect_valid(redirect_valid),
        .redirect_pc(redirect_pc), .ir_valid(ir_valid),
        .ir_ack(ir_ack), .ir(ir), .pc(pc), .opcode(opcode),
        .ra(ra), .rb(rb), .rc(rc), .c1(c1), .c2_sext(c2_sext),
        .fault(fault)
    );

    src_fetch_unit #(
        .ADDR_W(4), .RESET_PC(14), .PC_STEP(1), .TIMEOUT_CYC(8)
    ) dut2 (
        .clk(clk), .rst_n(rst2_n), .mem(bus2),
        .stall(stall), .redirect_valid(redirect2_valid),
        .redirect_pc(redirect2_pc), .ir_valid(ir_valid2),
        .ir_ack(ir_ack), .ir(ir2), .pc(pc2), .opcode(opcode2),
        .ra(ra2), .rb(rb2), .rc(rc2), .c1(c12), .c2_sext(c2_sext2),
        .fault(fault2)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] ref_c2(input logic [31:0] w);
        int v;
        v = int'(w % 32'd131072);
        if (v >= 65536) v = v - 131072;
        return 32'(v);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        int k;
        rst_n = 1'b0;
        stall = 1'b1;
        bus.mem_ack = 1'b0;
        bus.mem_rdata = '0;
        #2;
        n_tests++;
        if ({bus.mem_req, ir_valid, fault} !== 3'b000) begin
            n_fail++;
            $display("FAIL reset_ctrl req/valid/fault=%b expected 000",
                     {bus.mem_req, ir_valid, fault});
        end
        n_tests++;
        if (pc !== 16'd0 || bus.mem_addr !== 16'd0 || ir !== 32'd0) begin
            n_fail++;
            $display("FAIL reset_regs pc=%h addr=%h ir=%h expected 0",
                     pc, bus.mem_addr, ir);
        end
        n_tests++;
        if ({opcode, ra, rb, rc, c1, c2_sext} !== '0) begin
            n_fail++;
            $display("FAIL reset_decode fields not zero op=%h c2=%h",
                     opcode, c2_sext);
        end
        tick();
        rst_n = 1'b1;
        stall = 1'b0;
        k = 0;
        while (bus.mem_req !== 1'b1 && k < 10) begin
            tick();
            k++;
        end
        n_tests++;
        if (bus.mem_req !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_fetch_start mem_req=%b expected 1",
                     bus.mem_req);
        end
        #3;
        rst_n = 1'b0;
        #1;
        n_tests++;
        if (bus.mem_req !== 1'b0 || pc !== 16'd0) begin
            n_fail++;
            $display("FAIL reset_async req=%b pc=%h expected 0/0",
                     bus.mem_req, pc);
        end
    endtask

    task automatic test_first_fetch();
        logic [31:0] w;
        w = 32'h0A4A2005;
        rst_n = 1'b0;
        stall = 1'b0;
        ir_ack = 1'b1;
        tick();
        rst_n = 1'b1;
        tick();
        n_tests++;
        if (bus.mem_req !== 1'b1 || ir_valid !== 1'b0 ||
            bus.mem_addr !== 16'd0) begin
            n_fail++;
            $display("FAIL first_req req=%b valid=%b addr=%h exp 1/0/0",
                     bus.mem_req, ir_valid, bus.mem_addr);
        end
        bus.mem_ack = 1'b1;
        bus.mem_rdata = w;
        tick();
        bus.mem_ack = 1'b0;
        last_word = w;
        n_tests++;
        if (ir_valid !== 1'b1 || ir !== w) begin
            n_fail++;
            $display("FAIL first_valid valid=%b ir=%h expected 1/%h",
                     ir_valid, ir, w);
        end
        n_tests++;
        if (opcode !== 5'd1 || ra !== 5'd9 || rb !== 5'd5 ||
            c2_sext !== 32'h00002005) begin
            n_fail++;
            $display("FAIL first_decode op=%0d ra=%0d rb=%0d c2=%h exp 1/9/5/00002005",
                     opcode, ra, rb, c2_sext);
        end
        n_tests++;
        if (pc !== 16'd1) begin
            n_fail++;
            $display("FAIL first_pc pc=%h expected 1", pc);
        end
    endtask

    task automatic test_delayed_ack();
        logic [31:0] w;
        w = $urandom;
        tick();
        for (int i = 0; i < 3; i++) begin
            n_tests++;
            if (bus.mem_req !== 1'b1 || bus.mem_addr !== 16'd1) begin
                n_fail++;
                $display("FAIL delay_hold[%0d] req=%b addr=%h exp 1/0001",
                         i, bus.mem_req, bus.mem_addr);
            end
            stall = (i == 0);
            tick();
        end
        stall = 1'b0;
        n_tests++;
        if (bus.mem_req !== 1'b1 || ir_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL delay_pre_ack req=%b valid=%b exp 1/0",
                     bus.mem_req, ir_valid);
        end
        bus.mem_ack = 1'b1;
        bus.mem_rdata = w;
        ir_ack = 1'b0;
        tick();
        bus.mem_ack = 1'b0;
        last_word = w;
        n_tests++;
        if (ir_valid !== 1'b1 || ir !== w || pc !== 16'd2) begin
            n_fail++;
            $display("FAIL delay_valid valid=%b ir=%h pc=%h exp 1/%h/0002",
                     ir_valid, ir, pc, w);
        end
    endtask

    task automatic test_hold_stall();
        for (int i = 0; i < 5; i++) begin
            tick();
            n_tests++;
            if (ir_valid !== 1'b1 || ir !== last_word ||
                bus.mem_req !== 1'b0) begin
                n_fail++;
                $display("FAIL hold[%0d] valid=%b ir=%h req=%b exp 1/%h/0",
                         i, ir_valid, ir, bus.mem_req, last_word);
            end
        end
        ir_ack = 1'b1;
        stall = 1'b1;
        tick();
        ir_ack = 1'b0;
        tick();
        n_tests++;
        if (ir_valid !== 1'b0 || bus.mem_req !== 1'b0) begin
            n_fail++;
            $display("FAIL hold_idle valid=%b req=%b exp 0/0",
                     ir_valid, bus.mem_req);
        end
        stall = 1'b0;
        tick();
        n_tests++;
        if (bus.mem_req !== 1'b1 || bus.mem_addr !== 16'd2) begin
            n_fail++;
            $display("FAIL hold_restart req=%b addr=%h exp 1/0002",
                     bus.mem_req, bus.mem_addr);
        end
    endtask

    task automatic test_redirect();
        logic [31:0] w;
        bus.mem_ack = 1'b1;
        bus.mem_rdata = 32'hFFFFFFFF;
        redirect_valid = 1'b1;
        redirect_pc = 16'h0100;
        tick();
        bus.mem_ack = 1'b0;
        redirect_valid = 1'b0;
        n_tests++;
        if (ir_valid !== 1'b0 || ir !== last_word) begin
            n_fail++;
            $display("FAIL redir_discard valid=%b ir=%h exp 0/%h",
                     ir_valid, ir, last_word);
        end
        n_tests++;
        if (bus.mem_req !== 1'b1 || bus.mem_addr !== 16'h0100) begin
            n_fail++;
            $display("FAIL redir_addr req=%b addr=%h exp 1/0100",
                     bus.mem_req, bus.mem_addr);
        end
        w = $urandom;
        bus.mem_ack = 1'b1;
        bus.mem_rdata = w;
        tick();
        bus.mem_ack = 1'b0;
        last_word = w;
        n_tests++;
        if (ir_valid !== 1'b1 || ir !== w || pc !== 16'h0101) begin
            n_fail++;
            $display("FAIL redir_refetch valid=%b ir=%h pc=%h exp 1/%h/0101",
                     ir_valid, ir, pc, w);
        end
        redirect_valid = 1'b1;
        redirect_pc = 16'h0200;
        tick();
        redirect_valid = 1'b0;
        n_tests++;
        if (ir_valid !== 1'b0 || bus.mem_req !== 1'b1 ||
            bus.mem_addr !== 16'h0200) begin
            n_fail++;
            $display("FAIL redir_valid valid=%b req=%b addr=%h exp 0/1/0200",
                     ir_valid, bus.mem_req, bus.mem_addr);
        end
    endtask

    task automatic test_random();
        logic [15:0] exp_pc;
        logic [31:0] exp_ir;
        logic        exp_valid;
        logic        req_seen;
        int          waitc;
        int          n_fetch;
        exp_pc = 16'h0200;
        exp_ir = last_word;
        exp_valid = 1'b0;
        waitc = 0;
        n_fetch = 0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            n_tests++;
            if (pc !== exp_pc || ir !== exp_ir || ir_valid !== exp_valid) begin
                n_fail++;
                $display("FAIL rand_state cyc=%0d pc=%h ir=%h v=%b exp %h/%h/%b",
                         cyc, pc, ir, ir_valid, exp_pc, exp_ir, exp_valid);
            end
            n_tests++;
            if ((bus.mem_req && ir_valid) ||
                (bus.mem_req && bus.mem_addr !== exp_pc)) begin
                n_fail++;
                $display("FAIL rand_bus cyc=%0d req=%b v=%b addr=%h exp_pc=%h",
                         cyc, bus.mem_req, ir_valid, bus.mem_addr, exp_pc);
            end
            n_tests++;
            if (opcode !== 5'(exp_ir >> 27) ||
                ra !== 5'((exp_ir >> 22) % 32) ||
                rb !== 5'((exp_ir >> 17) % 32) ||
                rc !== 5'((exp_ir >> 12) % 32) ||
                c1 !== 22'(exp_ir % 32'h400000) ||
                c2_sext !== ref_c2(exp_ir)) begin
                n_fail++;
                $display("FAIL rand_decode cyc=%0d ir=%h op=%h c1=%h c2=%h",
                         cyc, exp_ir, opcode, c1, c2_sext);
            end
            req_seen = bus.mem_req;
            stall = ($urandom % 4) == 0;
            ir_ack = ($urandom % 2) == 0;
            redirect_valid = ($urandom % 16) == 0;
            redirect_pc = 16'($urandom);
            bus.mem_rdata = $urandom;
            if (req_seen)
                bus.mem_ack = (($urandom % 3) == 0) || (waitc >= 5);
            else
                bus.mem_ack = ($urandom % 8) == 0;
            if (req_seen && !bus.mem_ack) waitc++;
            else waitc = 0;
            if (redirect_valid) begin
                exp_pc = redirect_pc;
                exp_valid = 1'b0;
            end else if (req_seen && bus.mem_ack) begin
                exp_ir = bus.mem_rdata;
                exp_pc = exp_pc + 16'd1;
                exp_valid = 1'b1;
                n_fetch++;
            end else if (exp_valid && ir_ack) begin
                exp_valid = 1'b0;
            end
            tick();
        end
        bus.mem_ack = 1'b0;
        redirect_valid = 1'b0;
        stall = 1'b0;
        n_tests++;
        if (n_fetch < 100) begin
            n_fail++;
            $display("FAIL rand_progress fetches=%0d expected >= 100", n_fetch);
        end
    endtask

    task automatic test_wrap();
        int k;
        stall = 1'b0;
        ir_ack = 1'b1;
        bus2.mem_ack = 1'b0;
        bus2.mem_rdata = '0;
        rst2_n = 1'b0;
        tick();
        rst2_n = 1'b1;
        for (int n = 0; n < 3; n++) begin
            k = 0;
            while (bus2.mem_req !== 1'b1 && k < 8) begin
                tick();
                k++;
            end
            n_tests++;
            if (bus2.mem_req !== 1'b1 || bus2.mem_addr !== 4'((14 + n) % 16)) begin
                n_fail++;
                $display("FAIL wrap_addr[%0d] req=%b addr=%0d expected 1/%0d",
                         n, bus2.mem_req, bus2.mem_addr, (14 + n) % 16);
            end
            bus2.mem_ack = 1'b1;
            bus2.mem_rdata = $urandom;
            tick();
            bus2.mem_ack = 1'b0;
        end
        n_tests++;
        if (pc2 !== 4'd1 || ir_valid2 !== 1'b1) begin
            n_fail++;
            $display("FAIL wrap_pc pc=%0d valid=%b expected 1/1", pc2, ir_valid2);
        end
    endtask

    task automatic test_timeout();
        rst_n = 1'b0;
        stall = 1'b0;
        redirect_valid = 1'b0;
        bus.mem_ack = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
`ifdef SRC_FETCH_TIMEOUT_EN
        for (int i = 0; i < 8; i++) begin
            n_tests++;
            if (bus.mem_req !== 1'b1 || fault !== 1'b0) begin
                n_fail++;
                $display("FAIL tmo_wait[%0d] req=%b fault=%b exp 1/0",
                         i, bus.mem_req, fault);
            end
            tick();
        end
        for (int i = 0; i < 3; i++) begin
            n_tests++;
            if (bus.mem_req !== 1'b0 || fault !== 1'b1) begin
                n_fail++;
                $display("FAIL tmo_err[%0d] req=%b fault=%b exp 0/1",
                         i, bus.mem_req, fault);
            end
            tick();
        end
        redirect_valid = 1'b1;
        redirect_pc = 16'h0020;
        tick();
        redirect_valid = 1'b0;
        n_tests++;
        if (fault !== 1'b0 || bus.mem_req !== 1'b1 ||
            bus.mem_addr !== 16'h0020) begin
            n_fail++;
            $display("FAIL tmo_recover fault=%b req=%b addr=%h exp 0/1/0020",
                     fault, bus.mem_req, bus.mem_addr);
        end
`else
        for (int i = 0; i < 20; i++) begin
            n_tests++;
            if (bus.mem_req !== 1'b1 || fault !== 1'b0) begin
                n_fail++;
                $display("FAIL no_tmo[%0d] req=%b fault=%b exp 1/0",
                         i, bus.mem_req, fault);
            end
            tick();
        end
`endif
    endtask

    initial begin
        bus.mem_ack = 1'b0;
        bus.mem_rdata = '0;
        bus2.mem_ack = 1'b0;
        bus2.mem_rdata = '0;
        last_word = '0;
        test_reset();
        test_first_fetch();
        test_delayed_ack();
        test_hold_stall();
        test_redirect();
        test_random();
        test_wrap();
        test_timeout();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
